// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 3-sample majority filter, mid-bit sampling FSM; 1 start, DATA_WIDTH data, 1 stop.
// Latency ~CPB/2 + (DATA_WIDTH+1)*CPB cycles from start edge; no backpressure, axiov/ferr are single-cycle strobes.
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUDRATE    = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] axiod,
  output logic                  axiov,
  output logic                  ferr
);

  localparam int CPB = CLK_FREQ_HZ / BAUDRATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  generate
    if (CPB < 4 || DATA_WIDTH < 1) begin : g_bad_param
      $error("uart_rx: need CLK_FREQ_HZ/BAUDRATE >= 4 and DATA_WIDTH >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  rs_q, rs_d;
  logic [2:0]            hist_q, hist_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] axiod_q, axiod_d;
  logic                  axiov_q, axiov_d;
  logic                  ferr_q, ferr_d;
  logic                  sample;

  assign sync1_d = rxd;
  assign rs_d    = sync1_q;
  assign hist_d  = {hist_q[1:0], rs_q};
  assign sample  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    axiod_d = axiod_q;
    axiov_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rs_q) state_d = START;
      end
      START: begin
        // Mid start bit: a filtered high means the falling edge was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sample ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shreg_d[idx_q] = sample;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (sample) begin
            axiod_d = shreg_q;
            axiov_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rs_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rs_q    <= 1'b1;
      hist_q  <= 3'b111;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      axiod_q <= '0;
      axiov_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      rs_q    <= rs_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      axiod_q <= axiod_d;
      axiov_q <= axiov_d;
      ferr_q  <= ferr_d;
    end
  end

  assign axiod = axiod_q;
  assign axiov = axiov_q;
  assign ferr  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CPB = 10, DATA_WIDTH = 8: frames driven bit by bit,
// expected words queued on drive and matched when axiov fires.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] axiod;
  logic       axiov;
  logic       ferr;

  int         cyc;
  int         n_cmp;
  int         n_err;
  int         n_v;
  int         n_f;
  int         ferr_pending;
  int         t_start;
  logic       prev_v;
  logic       prev_f;
  logic [7:0] last_d;
  logic [7:0] exp_q[$];
  int         v_cyc[$];

  uart_rx #(
    .DATA_WIDTH (8),
    .CLK_FREQ_HZ(100_000_000),
    .BAUDRATE   (10_000_000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rxd  (rxd),
    .axiod(axiod),
    .axiov(axiov),
    .ferr (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      if (axiov && ferr) chk("strobe_overlap", 1, 0);
      if (axiov && prev_v) chk("axiov_width", 1, 0);
      if (ferr && prev_f) chk("ferr_width", 1, 0);
      if (!axiov && axiod !== last_d) chk("axiod_hold", {24'd0, axiod}, {24'd0, last_d});
      if (axiov) begin
        n_v = n_v + 1;
        v_cyc.push_back(cyc);
        last_d = axiod;
        if (exp_q.size() == 0) chk("unexpected_axiov", {24'd0, axiod}, 32'hffff_ffff);
        else chk("axiod", {24'd0, axiod}, {24'd0, exp_q.pop_front()});
      end
      if (ferr) begin
        n_f = n_f + 1;
        chk("ferr_expected", ferr_pending, 1);
        ferr_pending = 0;
      end
      prev_v = axiov;
      prev_f = ferr;
    end else begin
      last_d = 8'h00;
      prev_v = 1'b0;
      prev_f = 1'b0;
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    rxd = b;
    repeat (5) @(negedge clk);
    if (glitch) rxd = ~b;
    @(negedge clk);
    rxd = b;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    if (stop) exp_q.push_back(d);
    t_start = cyc + 1;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(stop, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_v = 0; n_f = 0; ferr_pending = 0;
    cyc = 0; t_start = 0; prev_v = 1'b0; prev_f = 1'b0; last_d = 8'h00;
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_axiod", {24'd0, axiod}, 0);
    chk("reset_axiov", {31'd0, axiov}, 0);
    chk("reset_ferr", {31'd0, ferr}, 0);
    rst = 1'b1;
    idle(20);

    // Single frame plus latency from the first edge that sees the line low
    send_frame(8'h4D, 1'b1, 1'b0);
    idle(5);
    chk("frame_count_single", n_v, 1);
    if (v_cyc.size() >= 1) chk("latency_in_window", ((v_cyc[0] - t_start) >= 92 && (v_cyc[0] - t_start) <= 98) ? 1 : 0, 1);

    // Back-to-back frames with zero idle time
    send_frame(8'h4D, 1'b1, 1'b0);
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h0D, 1'b1, 1'b0);
    send_frame(8'h0A, 1'b1, 1'b0);
    idle(10);
    chk("frame_count_b2b", n_v, 5);
    for (int i = 2; i < 5; i++)
      if (v_cyc.size() > i) chk("b2b_spacing", v_cyc[i] - v_cyc[i-1], 100);

    // Short glitch must be rejected, then a real frame follows
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    chk("glitch_no_axiov", n_v, 5);
    chk("glitch_no_ferr", n_f, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(5);
    chk("frame_count_55", n_v, 6);

    // Framing error: stop bit low, line held low another 30 cycles
    ferr_pending = 1;
    send_frame(8'hA5, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    chk("ferr_count", n_f, 1);
    chk("ferr_no_axiov", n_v, 6);
    chk("ferr_axiod_kept", {24'd0, axiod}, 32'h55);
    idle(20);
    chk("ferr_no_restart", n_v, 6);

    // Single-cycle glitches at every data-bit centre
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(5);
    chk("frame_count_glitch", n_v, 7);

    // Reset during bit 4 of 0xFF
    t_start = cyc + 1;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_axiod", {24'd0, axiod}, 0);
    chk("midreset_axiov", {31'd0, axiov}, 0);
    chk("midreset_ferr", {31'd0, ferr}, 0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(120);
    chk("no_strobe_after_abort", n_v, 7);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(10);
    chk("frame_count_final", n_v, 8);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("ferr_total", n_f, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
